// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared period counter, per-channel duty and polarity,
// with duty/period updates double-buffered and applied only at a period boundary.
module pwm_multi #(
    parameter int CBITS = 10,
    parameter int NCH   = 4,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CBITS-1:0] period,
    input  logic             duty_wr,
    input  logic [CHW-1:0]   duty_ch,
    input  logic [CBITS-1:0] duty_val,
    input  logic [NCH-1:0]   invert,
    output logic [NCH-1:0]   pwm_out,
    output logic             period_start,
    output logic [NCH-1:0]   upd_pending
);

    localparam logic [CHW:0] NCH_L = (CHW + 1)'(NCH);

    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [CBITS-1:0] per_q, per_d;
    logic [CBITS-1:0] duty_sh_q  [NCH];
    logic [CBITS-1:0] duty_sh_d  [NCH];
    logic [CBITS-1:0] duty_act_q [NCH];
    logic [CBITS-1:0] duty_act_d [NCH];
    logic [NCH-1:0]   pend_q, pend_d;
    logic [NCH-1:0]   pwm_q, pwm_d;
    logic             ps_q, ps_d;
    logic             xfer;
    logic             wr_ok;

    // Idle behaves as a permanent boundary so a restart always begins with fresh values.
    assign xfer  = !en || (cnt_q == per_q);
    assign wr_ok = duty_wr && ({1'b0, duty_ch} < NCH_L);

    always_comb begin
        cnt_d      = cnt_q;
        per_d      = per_q;
        duty_sh_d  = duty_sh_q;
        duty_act_d = duty_act_q;
        pend_d     = pend_q;
        pwm_d      = pwm_q;
        ps_d       = ps_q;

        if (xfer) begin
            cnt_d      = '0;
            per_d      = period;
            duty_act_d = duty_sh_q;
            pend_d     = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (en) begin
            for (int i = 0; i < NCH; i++) begin
                pwm_d[i] = (cnt_q < duty_act_q[i]) ^ invert[i];
            end
            ps_d = (cnt_q == '0);
        end else begin
            pwm_d = invert;
            ps_d  = 1'b0;
        end

        // A write coinciding with a transfer lands in the shadow after the old value moved.
        if (wr_ok) begin
            duty_sh_d[duty_ch] = duty_val;
            pend_d[duty_ch]    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            per_q  <= '1;
            pend_q <= '0;
            pwm_q  <= '0;
            ps_q   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            per_q      <= per_d;
            pend_q     <= pend_d;
            pwm_q      <= pwm_d;
            ps_q       <= ps_d;
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign upd_pending  = pend_q;

endmodule
